// File: rtl/interp_format_expander.sv
// rtl/interp_format_expander.sv - Q1.15 to accumulator-format expander with zero-stuffing interpolation
module interp_format_expander #(
  parameter int ACC_WIDTH = 42,
  parameter int ACC_FRAC  = 32,
  parameter int IN_WIDTH  = 16,
  parameter int IN_FRAC   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [4:0]           interp_factor,
  output logic [ACC_WIDTH-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 busy,
  output logic                 factor_err
);

  localparam int FRAC_DIFF = ACC_FRAC - IN_FRAC;

  // The gain shift (up to 4 bits) must fit in the integer headroom of the accumulator word.
  if (FRAC_DIFF < 0) begin : g_frac_chk
    $error("interp_format_expander: ACC_FRAC must be >= IN_FRAC");
  end
  if (ACC_WIDTH - ACC_FRAC < IN_WIDTH - IN_FRAC + 4) begin : g_gain_chk
    $error("interp_format_expander: not enough integer bits for gain compensation");
  end

  typedef enum logic [1:0] {IDLE, SAMPLE, ZEROS} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             phase_q, phase_d;
  logic [4:0]             l_q, l_d;
  logic [ACC_WIDTH-1:0]   data_q, data_d;
  logic                   ferr_q, ferr_d;

  logic [2:0]             k_new;
  logic [4:0]             l_new;
  logic                   factor_legal;
  logic                   last_beat;
  logic                   accept;
  logic signed [ACC_WIDTH-1:0] sample_ext;
  logic signed [ACC_WIDTH-1:0] sample_scaled;

  // Decode the requested factor into its log2; anything but a power of two up to 16 falls back to L=1.
  always_comb begin
    k_new        = 3'd0;
    factor_legal = 1'b1;
    case (interp_factor)
      5'd1:    k_new = 3'd0;
      5'd2:    k_new = 3'd1;
      5'd4:    k_new = 3'd2;
      5'd8:    k_new = 3'd3;
      5'd16:   k_new = 3'd4;
      default: factor_legal = 1'b0;
    endcase
    l_new = 5'd1 << k_new;
  end

  // Sign-extend, align the binary point, then apply the L gain that offsets zero-stuffing loss.
  assign sample_ext    = {{(ACC_WIDTH-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
  assign sample_scaled = (sample_ext <<< FRAC_DIFF) <<< k_new;

  assign last_beat = ((state_q == SAMPLE) && (l_q == 5'd1)) ||
                     ((state_q == ZEROS) && (phase_q == 5'd1));
  assign ready_out = (state_q == IDLE) || (last_beat && ready_in);
  assign accept    = valid_in && ready_out;

  assign valid_out  = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign data_out   = data_q;
  assign factor_err = ferr_q;

  // Burst sequencing: sample beat, then L-1 zero beats; a new accept on the last beat chains directly.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    l_d     = accept ? l_new : l_q;
    ferr_d  = accept && !factor_legal;
    data_d  = data_q;
    if (accept) begin
      data_d = sample_scaled;
    end else if (valid_out && ready_in) begin
      data_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (accept) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (ready_in) begin
          if (l_q == 5'd1) begin
            state_d = accept ? SAMPLE : IDLE;
          end else begin
            state_d = ZEROS;
            phase_d = l_q - 5'd1;
          end
        end
      end
      ZEROS: begin
        if (ready_in) begin
          if (phase_q == 5'd1) begin
            state_d = accept ? SAMPLE : IDLE;
          end else begin
            phase_d = phase_q - 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 5'd0;
      l_q     <= 5'd1;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      l_q     <= l_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule
